// File: rtl/sbox_hash_stream.sv
// Byte-streaming DES-S5 hash core. It absorbs a length-prefixed message, then runs
// NUM_H length-dependent finalisation rounds and publishes a registered digest.
module sbox_hash_stream #(
  parameter int                 NUM_H = 8,
  parameter int                 LEN_W = 64,
  parameter logic [4*NUM_H-1:0] IV    = 32'h30FD17B4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   C_in,
  input  logic [7:0]         M,
  input  logic               M_valid,
  output logic               M_ready,
  output logic               busy,
  output logic               hash_ready,
  output logic [4*NUM_H-1:0] digest
);
  localparam int JW = $clog2(NUM_H);

  typedef enum logic [1:0] {IDLE, ABSORB, FINAL} state_t;

  localparam logic [3:0] S5 [64] = '{
    4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,
    4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9,
    4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,
    4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6,
    4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,
    4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14,
    4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13,
    4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3
  };

  state_t                state_reg;
  logic [NUM_H-1:0][3:0] h_reg;
  logic [NUM_H-1:0][3:0] h_next;
  logic [LEN_W-1:0]      counter_reg;
  logic [LEN_W-1:0]      c_reg;
  logic [JW-1:0]         j_reg;
  logic [4*NUM_H-1:0]    digest_reg;
  logic                  hash_ready_reg;
  logic                  m_ready_reg;
  logic                  busy_reg;
  logic [7:0]            rnd_byte;
  logic [5:0]            m6;
  logic [3:0]            s;

  // c_reg shifts right each finalisation round, so byte j of C is always at the
  // bottom and rounds beyond LEN_W/8 naturally see zero.
  assign rnd_byte = (state_reg == FINAL) ? c_reg[7:0] : M;
  assign m6 = {rnd_byte[3] ^ rnd_byte[2], rnd_byte[1], rnd_byte[0],
               rnd_byte[7], rnd_byte[6], rnd_byte[5] ^ rnd_byte[4]};
  assign s  = S5[{m6[5], m6[0], m6[4:1]}];

  generate
    for (genvar gi = 0; gi < NUM_H; gi++) begin : g_lane
      localparam int ROT = (gi >> 1) % 4;
      logic [3:0] x;
      logic [7:0] xx;
      assign x  = h_reg[(gi + 1) % NUM_H] ^ s;
      assign xx = {x, x} << ROT;
      assign h_next[gi] = xx[7:4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      h_reg          <= IV;
      counter_reg    <= '0;
      c_reg          <= '0;
      j_reg          <= '0;
      digest_reg     <= '0;
      hash_ready_reg <= 1'b0;
      m_ready_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      hash_ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            counter_reg <= C_in;
            c_reg       <= C_in;
            h_reg       <= IV;
            j_reg       <= '0;
            busy_reg    <= 1'b1;
            m_ready_reg <= (C_in != '0);
            state_reg   <= (C_in != '0) ? ABSORB : FINAL;
          end
        end
        ABSORB: begin
          if (M_valid) begin
            h_reg       <= h_next;
            counter_reg <= counter_reg - LEN_W'(1);
            if (counter_reg == LEN_W'(1)) begin
              m_ready_reg <= 1'b0;
              state_reg   <= FINAL;
            end
          end
        end
        FINAL: begin
          h_reg <= h_next;
          c_reg <= c_reg >> 8;
          j_reg <= j_reg + JW'(1);
          if (j_reg == JW'(NUM_H - 1)) begin
            digest_reg     <= h_next;
            hash_ready_reg <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign M_ready    = m_ready_reg;
  assign busy       = busy_reg;
  assign hash_ready = hash_ready_reg;
  assign digest     = digest_reg;
endmodule

// File: tb/tb_sbox_hash_stream.sv
// Self-checking bench for sbox_hash_stream: a message-level hash model drives a
// per-cycle compare of the default core, plus directed runs on two small configs.
module tb_sbox_hash_stream;
  localparam int NH = 8;
  localparam logic [63:0] IV_MAIN = 64'h30FD17B4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, M_valid, M_ready, busy, hash_ready;
  logic [63:0] C_in;
  logic [7:0]  M;
  logic [31:0] digest;

  logic        start_a, M_valid_a, M_ready_a, busy_a, hash_ready_a;
  logic [7:0]  C_in_a, M_a, digest_a;
  logic        start_b, M_valid_b, M_ready_b, busy_b, hash_ready_b;
  logic [7:0]  C_in_b, M_b, digest_b;

  sbox_hash_stream dut (
    .clk(clk), .rst_n(rst_n), .start(start), .C_in(C_in), .M(M), .M_valid(M_valid),
    .M_ready(M_ready), .busy(busy), .hash_ready(hash_ready), .digest(digest));

  sbox_hash_stream #(.NUM_H(2), .LEN_W(8), .IV(8'h51)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .C_in(C_in_a), .M(M_a), .M_valid(M_valid_a),
    .M_ready(M_ready_a), .busy(busy_a), .hash_ready(hash_ready_a), .digest(digest_a));

  sbox_hash_stream #(.NUM_H(2), .LEN_W(8), .IV(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .C_in(C_in_b), .M(M_b), .M_valid(M_valid_b),
    .M_ready(M_ready_b), .busy(busy_b), .hash_ready(hash_ready_b), .digest(digest_b));

  int n_cmp = 0;
  int n_bad = 0;

  int s5_tab [64] = '{
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-message hash: n message bytes, then nh rounds fed by the bytes of c.
  function automatic logic [63:0] hash_model(input logic [63:0] iv, input int nh, input int lw,
                                             input logic [63:0] c, input logic [7:0] msg [16],
                                             input int n);
    int h [16];
    int hn [16];
    int row, col, s, x, r;
    logic [7:0]  b;
    logic [5:0]  m6;
    logic [63:0] d;
    for (int i = 0; i < nh; i++) h[i] = int'((iv >> (4 * i)) & 64'hF);
    for (int k = 0; k < n + nh; k++) begin
      if (k < n) b = msg[k];
      else if (k - n < lw / 8) b = 8'((c >> (8 * (k - n))) & 64'hFF);
      else b = 8'h00;
      m6  = {b[3] ^ b[2], b[1], b[0], b[7], b[6], b[5] ^ b[4]};
      row = int'({m6[5], m6[0]});
      col = int'(m6[4:1]);
      s   = s5_tab[16 * row + col];
      for (int i = 0; i < nh; i++) begin
        x = h[(i + 1) % nh] ^ s;
        r = (i >> 1) % 4;
        hn[i] = ((x << r) | (x >> (4 - r))) & 15;
      end
      for (int i = 0; i < nh; i++) h[i] = hn[i];
    end
    d = '0;
    for (int i = 0; i < nh; i++) d = d | (64'(h[i]) << (4 * i));
    return d;
  endfunction

  // Protocol-level expectation for the default core: 0 idle, 1 absorbing, 2 finalising.
  int          md = 0;
  int          fin_rem = 0;
  int          mn = 0;
  logic [63:0] m_rem = '0;
  logic [63:0] mc = '0;
  logic [7:0]  mmsg [16];
  logic        exp_hr = 1'b0;
  logic [31:0] exp_dg = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      md = 0; exp_hr = 1'b0; exp_dg = '0; mn = 0;
    end
    chk("busy", 64'(busy), 64'(md != 0));
    chk("m_ready", 64'(M_ready), 64'(md == 1));
    chk("hash_ready", 64'(hash_ready), 64'(exp_hr));
    chk("digest", 64'(digest), 64'(exp_dg));
    if (rst_n) begin
      exp_hr = 1'b0;
      case (md)
        0: if (start) begin
          mc = C_in; mn = 0;
          if (C_in != 0) begin md = 1; m_rem = C_in; end
          else begin md = 2; fin_rem = NH; end
        end
        1: if (M_valid) begin
          if (mn < 16) mmsg[mn] = M;
          mn++;
          m_rem = m_rem - 1;
          if (m_rem == 0) begin md = 2; fin_rem = NH; end
        end
        default: begin
          fin_rem--;
          if (fin_rem == 0) begin
            exp_dg = 32'(hash_model(IV_MAIN, NH, 64, mc, mmsg, (mn < 16) ? mn : 16));
            exp_hr = 1'b1;
            md = 0;
          end
        end
      endcase
    end
  end

  // Entered and left at posedge+2; on return the core is in its hash_ready cycle.
  task automatic run_hash(input int len, input bit fixed_gap, input bit noise);
    start = 1'b1; C_in = 64'(len); M_valid = 1'($urandom % 2); M = 8'($urandom);
    @(posedge clk); #2;
    start = 1'b0;
    for (int b = 0; b < len; b++) begin
      int gaps;
      gaps = fixed_gap ? ((b == 0) ? 0 : 2) : int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        M_valid = 1'b0; M = 8'($urandom);
        start = noise && ($urandom % 3 == 0); C_in = {$urandom, $urandom};
        @(posedge clk); #2;
      end
      M_valid = 1'b1; M = 8'($urandom);
      start = noise && ($urandom % 3 == 0); C_in = {$urandom, $urandom};
      @(posedge clk); #2;
    end
    M_valid = 1'b0;
    for (int k = 0; k < NH; k++) begin
      start = noise && ($urandom % 2 == 0); C_in = {$urandom, $urandom};
      M_valid = 1'($urandom % 2);
      @(posedge clk); #2;
    end
    start = 1'b0; M_valid = 1'b0;
    chk("hready_latency", 64'(hash_ready), 64'd1);
    $display("hash len=%0d noise=%0d digest=%h", len, noise, digest);
  endtask

  logic [7:0] pin_msg [16];
  int         n;
  logic       saw_rdy;

  initial begin
    rst_n = 1'b0; start = 1'b0; C_in = '0; M = '0; M_valid = 1'b0;
    start_a = 1'b0; C_in_a = '0; M_a = '0; M_valid_a = 1'b0;
    start_b = 1'b0; C_in_b = '0; M_b = '0; M_valid_b = 1'b0;
    for (int i = 0; i < 16; i++) pin_msg[i] = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_ready", 64'(M_ready), 64'd0);
    chk("rst_digest", 64'(digest), 64'd0);
    chk("rst_digest_a", 64'(digest_a), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Hand-derived values pin the model itself.
    chk("model_pin_51", hash_model(64'h51, 2, 8, 64'd1, pin_msg, 1), 64'h62);
    chk("model_pin_00", hash_model(64'h00, 2, 8, 64'd0, pin_msg, 0), 64'h00);

    // Small core, IV 51: one zero byte, M_valid also high (ignored) in the start cycle.
    start_a = 1'b1; C_in_a = 8'd1; M_valid_a = 1'b1; M_a = 8'hFF;
    @(posedge clk); #2;
    start_a = 1'b0; M_a = 8'h00;
    chk("a_m_ready", 64'(M_ready_a), 64'd1);
    chk("a_busy", 64'(busy_a), 64'd1);
    @(posedge clk); #2;
    M_a = 8'hAA;
    chk("a_m_ready_final", 64'(M_ready_a), 64'd0);
    n = 0;
    while (hash_ready_a !== 1'b1 && n < 10) begin @(posedge clk); #2; n++; end
    M_valid_a = 1'b0;
    chk("a_edges_to_hready", 64'(n), 64'd2);
    chk("a_digest", 64'(digest_a), 64'h62);
    $display("small IV=51 C=1 digest=%h after %0d cycles", digest_a, n + 1);
    @(posedge clk); #2;
    chk("a_hready_pulse", 64'(hash_ready_a), 64'd0);
    chk("a_digest_hold", 64'(digest_a), 64'h62);
    chk("a_idle", 64'(busy_a), 64'd0);

    // Small core, IV 00, zero length: straight to finalisation, no byte taken.
    start_b = 1'b1; C_in_b = 8'd0; M_valid_b = 1'b1; M_b = 8'h5A;
    @(posedge clk); #2;
    start_b = 1'b0;
    chk("b_busy", 64'(busy_b), 64'd1);
    saw_rdy = M_ready_b;
    n = 0;
    while (hash_ready_b !== 1'b1 && n < 10) begin
      @(posedge clk); #2; n++;
      saw_rdy = saw_rdy | M_ready_b;
    end
    M_valid_b = 1'b0;
    chk("b_edges_to_hready", 64'(n), 64'd2);
    chk("b_m_ready_low", 64'(saw_rdy), 64'd0);
    chk("b_digest", 64'(digest_b), 64'h00);
    $display("small IV=00 C=0 digest=%h after %0d cycles", digest_b, n + 1);

    // Default core: three bytes with two-cycle gaps, then ignored starts while busy.
    run_hash(3, 1'b1, 1'b0);
    @(posedge clk); #2;
    run_hash(4, 1'b0, 1'b1);
    run_hash(2, 1'b0, 1'b1);

    // Reset in the middle of absorption.
    start = 1'b1; C_in = 64'd5;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (2) begin M_valid = 1'b1; M = 8'($urandom); @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    chk("midrst_m_ready", 64'(M_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hready", 64'(hash_ready), 64'd0);
    chk("midrst_digest", 64'(digest), 64'd0);
    M_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    run_hash(5, 1'b0, 1'b0);

    for (int t = 0; t < 16; t++) begin
      run_hash(int'($urandom_range(0, 6)), 1'b0, 1'($urandom % 2));
      if ($urandom % 2 == 0) begin
        repeat ($urandom_range(1, 3)) begin
          M_valid = 1'($urandom % 2); M = 8'($urandom);
          @(posedge clk); #2;
        end
        M_valid = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
